// File: rtl/line_ser_pkg.sv
// Shared types and widths for the line pixel serializer.
package line_ser_pkg;

  typedef enum logic {S_IDLE, S_SEND} state_t;

  localparam int unsigned DEF_WIDTH  = 768;
  localparam int unsigned DEF_HEIGHT = 512;
  localparam int unsigned COL_W      = $clog2(DEF_WIDTH);
  localparam int unsigned ROW_W      = $clog2(DEF_HEIGHT);
  localparam int unsigned PIX_W      = 24;

endpackage

// File: rtl/line_bank_pair.sv
// Ping-pong line storage: two banks, each split into even/odd column arrays so one
// 48-bit write stores a whole pixel pair. Single asynchronous 24-bit read port.
module line_bank_pair
  import line_ser_pkg::*;
#(
  parameter int unsigned WIDTH = 768,
  parameter int unsigned ColW  = $clog2(WIDTH)
) (
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic                 wr_bank,
  input  logic [ColW-2:0]      wr_addr,
  input  logic [2*PIX_W-1:0]   wr_data,  // {even pixel, odd pixel}
  input  logic                 rd_bank,
  input  logic [ColW-1:0]      rd_col,
  output logic [PIX_W-1:0]     rd_data
);

  localparam int unsigned Half = WIDTH / 2;

  logic [PIX_W-1:0] even_mem [2][Half];
  logic [PIX_W-1:0] odd_mem  [2][Half];

  // Pixel-pair write; storage is not reset, validity lives in the top's full flags.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      even_mem[wr_bank][wr_addr] <= wr_data[2*PIX_W-1:PIX_W];
      odd_mem[wr_bank][wr_addr]  <= wr_data[PIX_W-1:0];
    end
  end

  // Column LSB picks the even or odd array.
  always_comb begin
    rd_data = rd_col[0] ? odd_mem[rd_bank][rd_col[ColW-1:1]]
                        : even_mem[rd_bank][rd_col[ColW-1:1]];
  end

endmodule

// File: rtl/line_pixel_serializer.sv
// Converts a 2 px/clk HSYNC-qualified RGB stream into a 1 px/clk valid/ready stream
// via a ping-pong line buffer, tagging end-of-line and end-of-frame.
module line_pixel_serializer
  import line_ser_pkg::*;
#(
  parameter int unsigned WIDTH  = 768,  // even, >= 4
  parameter int unsigned HEIGHT = 512   // >= 2
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic             VSYNC,
  input  logic             HSYNC,
  input  logic [7:0]       DATA_R0,
  input  logic [7:0]       DATA_G0,
  input  logic [7:0]       DATA_B0,
  input  logic [7:0]       DATA_R1,
  input  logic [7:0]       DATA_G1,
  input  logic [7:0]       DATA_B1,
  output logic [PIX_W-1:0] PIX_RGB,
  output logic             PIX_VALID,
  input  logic             PIX_READY,
  output logic             PIX_EOL,
  output logic             PIX_EOF,
  output logic             OVERFLOW,
  output logic             LINE_ERR
);

  localparam int unsigned ColW = $clog2(WIDTH);
  localparam int unsigned RowW = $clog2(HEIGHT);
  localparam logic [ColW-1:0] LastPair = ColW'(WIDTH - 2);
  localparam logic [ColW-1:0] LastCol  = ColW'(WIDTH - 1);
  localparam logic [RowW-1:0] LastRow  = RowW'(HEIGHT - 1);

  // Write side state
  logic            hsync_q;
  logic [ColW-1:0] wr_col_q, wr_col_d;
  logic [RowW-1:0] in_row_q, in_row_d;
  logic            wr_bank_q, wr_bank_d;
  logic            drop_q, drop_d;
  logic            overflow_q, overflow_d;
  logic            line_err_q, line_err_d;
  logic [1:0]      full_q, full_d, set_full, clr_full;

  // Read side state
  state_t          state_q, state_d;
  logic            rd_bank_q, rd_bank_d;
  logic [ColW-1:0] rd_col_q, rd_col_d;
  logic [RowW-1:0] out_row_q, out_row_d;
  logic [PIX_W-1:0] pix_rgb_q, pix_rgb_d;
  logic            pix_valid_q, pix_valid_d;
  logic            pix_eol_q, pix_eol_d;
  logic            pix_eof_q, pix_eof_d;

  logic            beat, line_start, drop, wr_en;
  logic            rd_sel_bank, load, accept;
  logic [ColW-1:0] rd_sel_col;
  logic [PIX_W-1:0] rd_data;

  line_bank_pair #(
    .WIDTH (WIDTH),
    .ColW  (ColW)
  ) u_banks (
    .clk     (HCLK),
    .wr_en   (wr_en),
    .wr_bank (wr_bank_q),
    .wr_addr (wr_col_q[ColW-1:1]),
    .wr_data ({DATA_R0, DATA_G0, DATA_B0, DATA_R1, DATA_G1, DATA_B1}),
    .rd_bank (rd_sel_bank),
    .rd_col  (rd_sel_col),
    .rd_data (rd_data)
  );

  // Write side: column/row tracking, bank fill, drop-on-overflow and short-line detection.
  always_comb begin
    beat       = HSYNC && !VSYNC;
    line_start = beat && (wr_col_q == '0);
    // Drop decision is taken on a line's first beat and held for the rest of it.
    drop       = line_start ? full_q[wr_bank_q] : drop_q;
    wr_en      = beat && !drop;
    set_full   = '0;
    wr_col_d   = wr_col_q;
    in_row_d   = in_row_q;
    wr_bank_d  = wr_bank_q;
    drop_d     = drop_q;
    overflow_d = overflow_q;
    line_err_d = line_err_q;
    if (VSYNC) begin
      wr_col_d = '0;
      in_row_d = '0;
      drop_d   = 1'b0;
    end else if (beat) begin
      drop_d = drop;
      if (line_start && full_q[wr_bank_q]) begin
        overflow_d = 1'b1;
      end
      if (wr_col_q == LastPair) begin
        wr_col_d = '0;
        in_row_d = (in_row_q == LastRow) ? '0 : in_row_q + RowW'(1);
        drop_d   = 1'b0;
        if (!drop) begin
          set_full[wr_bank_q] = 1'b1;
          wr_bank_d           = ~wr_bank_q;
        end
      end else begin
        wr_col_d = wr_col_q + ColW'(2);
      end
    end else if (hsync_q && (wr_col_q != '0)) begin
      line_err_d = 1'b1;
      wr_col_d   = '0;
      drop_d     = 1'b0;
    end
  end

  // Read side FSM: stream the current bank, chaining straight into the other bank if full.
  always_comb begin
    accept      = pix_valid_q && PIX_READY;
    state_d     = state_q;
    rd_bank_d   = rd_bank_q;
    rd_col_d    = rd_col_q;
    out_row_d   = out_row_q;
    pix_rgb_d   = pix_rgb_q;
    pix_valid_d = pix_valid_q;
    pix_eol_d   = pix_eol_q;
    pix_eof_d   = pix_eof_q;
    clr_full    = '0;
    rd_sel_bank = rd_bank_q;
    rd_sel_col  = rd_col_q;
    load        = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        rd_sel_col = '0;
        if (full_q[rd_bank_q]) begin
          load     = 1'b1;
          rd_col_d = ColW'(1);
          state_d  = S_SEND;
        end
      end
      S_SEND: begin
        if (accept) begin
          if (pix_eol_q) begin
            clr_full[rd_bank_q] = 1'b1;
            rd_bank_d           = ~rd_bank_q;
            out_row_d           = (out_row_q == LastRow) ? '0 : out_row_q + RowW'(1);
            if (full_q[~rd_bank_q]) begin
              rd_sel_bank = ~rd_bank_q;
              rd_sel_col  = '0;
              load        = 1'b1;
              rd_col_d    = ColW'(1);
            end else begin
              pix_valid_d = 1'b0;
              pix_eol_d   = 1'b0;
              pix_eof_d   = 1'b0;
              state_d     = S_IDLE;
            end
          end else begin
            load     = 1'b1;
            rd_col_d = rd_col_q + ColW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (load) begin
      pix_rgb_d   = rd_data;
      pix_valid_d = 1'b1;
      pix_eol_d   = (rd_sel_col == LastCol);
      pix_eof_d   = (rd_sel_col == LastCol) && (out_row_d == LastRow);
    end
    full_d = (full_q | set_full) & ~clr_full;
  end

  // All control and output state, cleared asynchronously.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      hsync_q     <= 1'b0;
      wr_col_q    <= '0;
      in_row_q    <= '0;
      wr_bank_q   <= 1'b0;
      drop_q      <= 1'b0;
      overflow_q  <= 1'b0;
      line_err_q  <= 1'b0;
      full_q      <= '0;
      state_q     <= S_IDLE;
      rd_bank_q   <= 1'b0;
      rd_col_q    <= '0;
      out_row_q   <= '0;
      pix_rgb_q   <= '0;
      pix_valid_q <= 1'b0;
      pix_eol_q   <= 1'b0;
      pix_eof_q   <= 1'b0;
    end else begin
      hsync_q     <= HSYNC;
      wr_col_q    <= wr_col_d;
      in_row_q    <= in_row_d;
      wr_bank_q   <= wr_bank_d;
      drop_q      <= drop_d;
      overflow_q  <= overflow_d;
      line_err_q  <= line_err_d;
      full_q      <= full_d;
      state_q     <= state_d;
      rd_bank_q   <= rd_bank_d;
      rd_col_q    <= rd_col_d;
      out_row_q   <= out_row_d;
      pix_rgb_q   <= pix_rgb_d;
      pix_valid_q <= pix_valid_d;
      pix_eol_q   <= pix_eol_d;
      pix_eof_q   <= pix_eof_d;
    end
  end

  assign PIX_RGB   = pix_rgb_q;
  assign PIX_VALID = pix_valid_q;
  assign PIX_EOL   = pix_eol_q;
  assign PIX_EOF   = pix_eof_q;
  assign OVERFLOW  = overflow_q;
  assign LINE_ERR  = line_err_q;

endmodule

// File: tb/tb_line_pixel_serializer.sv
// Scoreboard bench for line_pixel_serializer with WIDTH=8, HEIGHT=4.
module tb_line_pixel_serializer;

  localparam int W = 8;
  localparam int H = 4;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        VSYNC = 1'b0;
  logic        HSYNC = 1'b0;
  logic [7:0]  DATA_R0 = '0, DATA_G0 = '0, DATA_B0 = '0;
  logic [7:0]  DATA_R1 = '0, DATA_G1 = '0, DATA_B1 = '0;
  logic [23:0] PIX_RGB;
  logic        PIX_VALID, PIX_READY, PIX_EOL, PIX_EOF, OVERFLOW, LINE_ERR;

  typedef struct packed {
    logic [23:0] rgb;
    logic        eol;
    logic        eof;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   exp_row = 0;
  int   acc_cnt = 0;
  int   ready_mode = 0;  // 0: always ready, 1: toggle, 2: held low

  always #5 HCLK = ~HCLK;

  line_pixel_serializer #(
    .WIDTH  (W),
    .HEIGHT (H)
  ) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .VSYNC     (VSYNC),
    .HSYNC     (HSYNC),
    .DATA_R0   (DATA_R0),
    .DATA_G0   (DATA_G0),
    .DATA_B0   (DATA_B0),
    .DATA_R1   (DATA_R1),
    .DATA_G1   (DATA_G1),
    .DATA_B1   (DATA_B1),
    .PIX_RGB   (PIX_RGB),
    .PIX_VALID (PIX_VALID),
    .PIX_READY (PIX_READY),
    .PIX_EOL   (PIX_EOL),
    .PIX_EOF   (PIX_EOF),
    .OVERFLOW  (OVERFLOW),
    .LINE_ERR  (LINE_ERR)
  );

  function automatic logic [23:0] pv(int tag, int row, int col);
    return {tag[7:0], row[7:0], col[7:0]};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  // Queue the first npix pixels of a line; the row model advances once per line.
  task automatic push_line(int tag, int row, int npix);
    exp_t x;
    for (int c = 0; c < npix; c++) begin
      x.rgb = pv(tag, row, c);
      x.eol = (c == W - 1);
      x.eof = (c == W - 1) && (exp_row == H - 1);
      exp_q.push_back(x);
    end
    exp_row = (exp_row + 1) % H;
  endtask

  task automatic send_line(int tag, int row, int nbeats, int npush);
    logic [23:0] e, o;
    if (npush > 0) push_line(tag, row, npush);
    for (int k = 0; k < nbeats; k++) begin
      e = pv(tag, row, 2 * k);
      o = pv(tag, row, 2 * k + 1);
      {DATA_R0, DATA_G0, DATA_B0} = e;
      {DATA_R1, DATA_G1, DATA_B1} = o;
      HSYNC = 1'b1;
      tick();
    end
    HSYNC = 1'b0;
  endtask

  task automatic vsync_pulse();
    VSYNC = 1'b1;
    tick();
    VSYNC = 1'b0;
  endtask

  task automatic drain(string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      tick();
      n++;
    end
    chk(name, exp_q.size(), 0);
    exp_q.delete();
    repeat (4) tick();
  endtask

  // Sink ready pattern
  initial begin
    PIX_READY = 1'b1;
    forever begin
      @(posedge HCLK);
      #1;
      case (ready_mode)
        1:       PIX_READY = ~PIX_READY;
        2:       PIX_READY = 1'b0;
        default: PIX_READY = 1'b1;
      endcase
    end
  end

  // Monitor: pops on every accepted pixel and checks hold behaviour while stalled.
  initial begin
    logic        stall_prev;
    logic [25:0] held;
    exp_t        x;
    stall_prev = 1'b0;
    held = '0;
    forever begin
      @(negedge HCLK);
      if (!HRESETn) begin
        stall_prev = 1'b0;
        continue;
      end
      if (stall_prev) chk("stall_hold", {PIX_VALID, PIX_RGB, PIX_EOL, PIX_EOF}, {1'b1, held});
      if (PIX_VALID && PIX_READY) begin
        acc_cnt++;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL extra_pixel: got %0h expected no pixel (t=%0t)", PIX_RGB, $time);
        end else begin
          x = exp_q.pop_front();
          chk("pixel", {PIX_RGB, PIX_EOL, PIX_EOF}, {x.rgb, x.eol, x.eof});
        end
      end
      stall_prev = PIX_VALID && !PIX_READY;
      held = {PIX_RGB, PIX_EOL, PIX_EOF};
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, n, found;

    // Reset state
    repeat (3) tick();
    chk("rst_valid", PIX_VALID, 0);
    chk("rst_rgb", PIX_RGB, 0);
    chk("rst_eol_eof", {PIX_EOL, PIX_EOF}, 0);
    chk("rst_flags", {OVERFLOW, LINE_ERR}, 0);
    HRESETn = 1'b1;
    repeat (2) tick();

    // Clean frame, 4-clk gap
    vsync_pulse();
    for (int r = 0; r < H; r++) begin
      send_line(1, r, W / 2, W);
      repeat (4) tick();
    end
    drain("clean_drain");
    chk("clean_overflow", OVERFLOW, 0);
    chk("clean_line_err", LINE_ERR, 0);

    // Backpressure with ready toggling
    ready_mode = 1;
    vsync_pulse();
    for (int r = 0; r < H; r++) begin
      send_line(2, r, W / 2, W);
      repeat (12) tick();
    end
    drain("bp_drain");
    ready_mode = 0;
    tick();
    chk("bp_overflow", OVERFLOW, 0);

    // Gap 0 with sink stalled: third line overflows
    ready_mode = 2;
    tick();
    vsync_pulse();
    send_line(3, 0, W / 2, W);
    send_line(3, 1, W / 2, W);
    send_line(3, 2, W / 2, 0);
    repeat (2) tick();
    chk("ovf_set", OVERFLOW, 1);
    repeat (6) tick();
    chk("ovf_stalled_valid", PIX_VALID, 1);
    ready_mode = 0;
    drain("ovf_drain");
    chk("ovf_idle_after", PIX_VALID, 0);
    chk("ovf_no_line_err", LINE_ERR, 0);

    // Short line then normal lines
    send_line(4, 0, 2, 0);
    repeat (3) tick();
    chk("line_err_set", LINE_ERR, 1);
    chk("line_err_no_out", PIX_VALID, 0);
    send_line(4, 1, W / 2, W);
    repeat (4) tick();
    send_line(4, 2, W / 2, W);
    drain("lerr_drain");

    // Reset mid-way through the second line's output
    base = acc_cnt;
    send_line(5, 0, W / 2, W);
    send_line(5, 1, W / 2, 3);
    n = 0;
    while (acc_cnt < base + W + 3 && n < 100) begin
      @(negedge HCLK);
      #1;
      n++;
    end
    chk("rst_mid_reached", (acc_cnt >= base + W + 3), 1);
    HRESETn = 1'b0;
    #1;
    chk("async_rst_valid", PIX_VALID, 0);
    chk("async_rst_rgb", PIX_RGB, 0);
    chk("async_rst_eol", PIX_EOL, 0);
    repeat (3) tick();
    HRESETn = 1'b1;
    chk("rst_expect_flushed", exp_q.size(), 0);
    exp_q.delete();
    exp_row = 0;
    repeat (20) tick();
    chk("post_rst_idle", PIX_VALID, 0);
    chk("post_rst_flags", {OVERFLOW, LINE_ERR}, 0);

    // VSYNC while row 3 drains; new frame row 0 follows without a bubble
    vsync_pulse();
    for (int r = 0; r < H - 1; r++) begin
      send_line(6, r, W / 2, W);
      repeat (4) tick();
    end
    send_line(6, H - 1, W / 2, W);
    vsync_pulse();
    tick();
    send_line(7, 0, W / 2, W);
    found = 0;
    for (int k = 0; k < 40 && found == 0; k++) begin
      @(negedge HCLK);
      if (PIX_VALID && PIX_READY && PIX_EOF) found = 1;
    end
    chk("vs_eof_seen", found, 1);
    @(negedge HCLK);
    chk("vs_no_bubble", PIX_VALID, 1);
    drain("vs_drain");
    chk("vs_flags", {OVERFLOW, LINE_ERR}, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
